// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Optional early-out multiply is enabled with MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [63:0] DIV0_LO = '1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared engine.
// Shift-add multiply or restoring divide on a 2*XLEN+1 bit accumulator.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode_div,
    input  logic [2*XLEN:0] acc_i,
    input  logic [XLEN-1:0] operand,
    output logic [2*XLEN:0] acc_o,
    output logic            q_bit
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;

    // Upper XLEN+1 bits hold the partial product or the remainder.
    always_comb begin
        sum    = acc_i[2*XLEN:XLEN]
               + {1'b0, {XLEN{acc_i[0]}} & operand};
        rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        trial  = {1'b0, rem_sh} - {2'b00, operand};
        q_bit  = 1'b0;
        acc_o  = '0;
        if (mode_div) begin
            q_bit = ~trial[XLEN+1];
            acc_o = {q_bit ? trial[XLEN:0] : rem_sh,
                     acc_i[XLEN-2:0], q_bit};
        end else begin
            acc_o = {1'b0, sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and sequencer for the iterative multiply/divide engine.
// Define MULDIV_EARLY_OUT_EN to let multiplies leave CALC early.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op_code,
    output logic            op_ready,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            mf_valid,
    input  logic            mf_sel,
    output logic [XLEN-1:0] mf_data,
    output logic            stall,
    output logic            busy,
    output logic            done,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   raw_a_q, raw_a_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              div0_q, div0_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     shamt;
`endif

    logic [2*XLEN:0]   step_acc;
    logic              step_q;
    logic              accept;
    logic              last;
    logic              sgn_op;
    logic              div_op;
    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem;
    op_t               op;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode_div (is_div_q),
        .acc_i    (acc_q),
        .operand  (opnd_q),
        .acc_o    (step_acc),
        .q_bit    (step_q)
    );

    assign busy     = (state_q != IDLE);
    assign op_ready = (state_q == IDLE) & ~flush;
    assign stall    = busy & (op_valid | mf_valid);
    assign done     = (state_q == FIXUP) & ~flush;
    assign mf_data  = mf_sel ? hi_q : lo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Operand decode, iteration control and result write-back.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        raw_a_d  = raw_a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        div0_d   = div0_q;
`ifdef MULDIV_EARLY_OUT_EN
        mplier_d = mplier_q;
        shamt    = CW'(XLEN) - count_q;
`endif
        op      = op_t'(op_code);
        accept  = op_valid & op_ready;
        sgn_op  = (op == OP_MULT) | (op == OP_DIV);
        div_op  = (op == OP_DIV) | (op == OP_DIVU);
        sa      = sgn_op & src_a[XLEN-1];
        sb      = sgn_op & src_b[XLEN-1];
        mag_a   = sa ? -src_a : src_a;
        mag_b   = sb ? -src_b : src_b;
`ifdef MULDIV_EARLY_OUT_EN
        last    = (count_q == CW'(XLEN - 1))
                | (~is_div_q & (mplier_q[XLEN-1:1] == '0));
        prod    = acc_q[2*XLEN-1:0] >> shamt;
`else
        last    = (count_q == CW'(XLEN - 1));
        prod    = acc_q[2*XLEN-1:0];
`endif
        prod_s  = negq_q ? -prod : prod;
        quo     = acc_q[XLEN-1:0];
        rem     = acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d = div_op;
                            negq_d   = sa ^ sb;
                            negr_d   = sa;
                            div0_d   = div_op & (src_b == '0);
                            raw_a_d  = src_a;
                            acc_d    = div_op ? {{(XLEN+1){1'b0}}, mag_a}
                                              : {{(XLEN+1){1'b0}}, mag_b};
                            opnd_d   = div_op ? mag_b : mag_a;
`ifdef MULDIV_EARLY_OUT_EN
                            mplier_d = mag_b;
`endif
                            count_d  = '0;
                            state_d  = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = step_acc;
                    count_d = count_q + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    mplier_d = mplier_q >> 1;
`endif
                    if (last) state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!flush) begin
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_s;
                    end else if (div0_q) begin
                        lo_d = DIV0_LO[XLEN-1:0];
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = negq_q ? -quo : quo;
                        hi_d = negr_q ? -rem : rem;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unused quotient bit: the step already folds it into the accumulator.
    logic unused_q;
    assign unused_q = step_q;

    // State, datapath and architectural register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            raw_a_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            raw_a_q  <= raw_a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            div0_q   <= div0_d;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
// Latency checks assume the default build unless MULDIV_EARLY_OUT_EN.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic        op_ready;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mf_valid = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] mf_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic        flush = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total = 0;
    int done_cnt = 0;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_ready (op_ready),
        .src_a    (src_a),
        .src_b    (src_b),
        .mf_valid (mf_valid),
        .mf_sel   (mf_sel),
        .mf_data  (mf_data),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .flush    (flush),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        op_code  = op;
        src_a    = a;
        src_b    = b;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int bcyc);
        bcyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcyc++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output int bcyc);
        issue(op, a, b);
        wait_idle(bcyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int d0;
        int sc;
        int fl;

        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, op_ready}, 32'd1);

        d0 = done_cnt;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, b);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        check("mult_done1", done_cnt - d0, 32'd1);
`ifndef MULDIV_EARLY_OUT_EN
        check("mult_busy33", b, 32'd33);
`endif

        run_op(3'd3, 32'd100, 32'd7, b);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        check("divu_busy33", b, 32'd33);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, b);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(3'd1, 32'd6, 32'd7);
        mf_valid = 1'b1;
        mf_sel = 1'b0;
        sc = 0;
        b = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            b++;
            if (stall) sc++;
        end
        check("mf_stall_all", sc, b);
        check("mf_stall_drop", {31'd0, stall}, 32'd0);
        check("mf_data42", mf_data, 32'd42);
`ifndef MULDIV_EARLY_OUT_EN
        check("mf_stall33", sc, 32'd33);
`endif
        mf_valid = 1'b0;

        run_op(3'd2, 32'd5, 32'd0, b);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd5);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, b);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        run_op(3'd4, 32'h1234_5678, 32'd0, b);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h8000_0000);
        check("mthi_nobusy", b, 32'd0);

        @(negedge clk);
        flush = 1'b1;
        op_valid = 1'b1;
        op_code = 3'd5;
        src_a = 32'hDEAD_BEEF;
        #1 check("flush_idle_rdy", {31'd0, op_ready}, 32'd0);
        @(posedge clk);
        #1 op_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_lo", lo, 32'h8000_0000);

`ifdef MULDIV_EARLY_OUT_EN
        fl = 2;
`else
        fl = 10;
`endif
        d0 = done_cnt;
        issue(3'd0, 32'd9, 32'd9);
        repeat (fl) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("flush_hi", hi, 32'h1234_5678);
        check("flush_lo", lo, 32'h8000_0000);
        check("flush_nodone", done_cnt - d0, 32'd0);

        @(negedge clk);
        op_valid = 1'b1;
        op_code = 3'd1;
        src_a = 32'd2;
        src_b = 32'd2;
        mf_valid = 1'b1;
        mf_sel = 1'b1;
        #1 check("same_stall", {31'd0, stall}, 32'd0);
        check("same_mfdata", mf_data, 32'h1234_5678);
        @(posedge clk);
        #1 op_valid = 1'b0;
        check("same_stall_busy", {31'd0, stall}, 32'd1);
        mf_valid = 1'b0;
        wait_idle(b);
        check("same_lo", lo, 32'd4);
        check("same_hi", hi, 32'd0);

        issue(3'd1, 32'd3, 32'h8000_0001);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", {31'd0, op_ready}, 32'd1);

        @(negedge clk);
        op_valid = 1'b1;
        op_code = 3'd6;
        src_a = 32'd1;
        #1 check("op6_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        check("op6_busy", {31'd0, busy}, 32'd0);
        check("op6_hi", hi, 32'd0);

`ifdef MULDIV_EARLY_OUT_EN
        run_op(3'd1, 32'd3, 32'd5, b);
        check("early_fast", {31'd0, b <= 4}, 32'd1);
        check("early_lo", lo, 32'd15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Owns the HI/LO architectural registers and sequences a shared iterative 32-cycle multiply/divide engine for MULT, MULTU, DIV and DIVU.
- Also executes MTHI and MTLO, and serves MFHI/MFLO reads.
- Generates the pipeline stall whenever HI/LO is requested while an operation is in flight.
- Sits beside the ALU in the execute stage.

Parameters:
XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  request to issue op_code this cycle
op_code  in  3  muldiv_pkg::op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5
op_ready  out  1  op accepted this cycle when op_valid & op_ready
src_a  in  XLEN  rs operand (multiplicand/dividend/MT source)
src_b  in  XLEN  rt operand (multiplier/divisor)
mf_valid  in  1  MFHI/MFLO read request
mf_sel  in  1  0=LO, 1=HI
mf_data  out  XLEN  selected HI or LO register value (combinational)
stall  out  1  hold the pipeline
busy  out  1  engine not IDLE
done  out  1  one-cycle pulse in FIXUP
flush  in  1  abort the in-flight operation
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=lo=0, count=0, done=0, busy=0, op_ready=1 after release.
- op_ready = (state==IDLE) & ~flush.
- stall = busy & (op_valid | mf_valid).
- mf_data is always the current register value. It is valid for the pipeline only when stall=0.
- MTHI/MTLO: accepted in IDLE; hi (or lo) <= src_a at the accepting edge. State stays IDLE; no other effect.
- MULT/MULTU/DIV/DIVU accept (edge E):
  - Latch |src_a| and |src_b|. Signed ops take two's-complement magnitude; unsigned ops take the raw value.
  - Latch neg_q = sa^sb and neg_r = sa, where sa/sb are the operand signs (0 for unsigned ops).
  - Latch div0 = (src_b==0) for divides.
  - count <= 0; state <= CALC.
- CALC, one iteration per cycle, count 0..XLEN-1; after count==XLEN-1, state <= FIXUP.
  - Multiply: 2*XLEN+1-bit shift-add accumulator. If the accumulator lsb is 1, add the multiplicand into the upper XLEN+1 bits; then shift right by 1.
  - Divide: restoring. rem = {rem, dividend msb}; trial = rem - divisor. If trial >= 0: rem = trial, quotient bit = 1; else quotient bit = 0.
- FIXUP, 1 cycle: done=1. At the leaving edge, state <= IDLE and hi/lo are written:
  - mult: {hi,lo} = neg_q ? -P : P.
  - div: lo = neg_q ? -Q : Q; hi = neg_r ? -R : R.
  - div0 overrides: lo = all ones, hi = src_a latched raw.
  - INT_MIN / -1 yields lo=0x80000000, hi=0; no trap.
- Latency: accepted at edge E, hi/lo updated at edge E+XLEN+1. busy=1 for XLEN+1 cycles.
- flush:
  - In CALC or FIXUP: next edge state <= IDLE, hi/lo unchanged, done suppressed.
  - In IDLE: blocks acceptance that cycle.
- IDLE with op_valid and mf_valid in the same cycle: mf_data returns the pre-op value; stall=0.
- op_code 6/7: ignored, op_ready still 1.
- Reset asserted mid-operation: immediate IDLE; hi=lo=0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply exits CALC to FIXUP once the remaining multiplier bits are all zero. The accumulator is shifted to its final alignment in FIXUP; results are identical to the non-early-out case. Divide is unaffected.
- Undefined: fixed XLEN+1-cycle latency for all ops.

Decomposition:
- muldiv_pkg holds:
  - op_t enum
  - state_t enum (IDLE, CALC, FIXUP)
  - XLEN default
  - DIV0_LO constant (all ones)
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
  - The sequencer holds all registers and the counter.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses exactly once.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9/2 (-7/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULTU 6*7, then MFLO issued the next cycle → stall=1 throughout busy; stall drops the cycle after FIXUP with mf_data=42.
- DIV 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, then MULT 9*9 with flush at CALC count 10 → IDLE next cycle, hi=0x12345678, done never asserted.
- rst_n low at CALC count 5 → hi=lo=0, busy=0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 3*5 → done within 4 cycles, lo=15.
